// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multi-cycle MIPS control unit
//   state_t   - 4-bit binary FSM state encoding (13..15 unused)
//   OP_*      - supported instruction opcodes
//   ALU_*     - ALU_op codes consumed by the ALU control unit
//   PCSRC_*   - PC source mux encodings
//   SRCB_*    - ALU B-operand mux encodings
//   ctrl_t    - packed control word produced by the output decoder
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_EXEC_I   = 4'd10,
        S_WB_I     = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_ORI  = 6'd13;
    localparam logic [5:0] OP_LUI  = 6'd15;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b011;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
                          OP_ORI, OP_LUI, OP_LW, OP_SW};
    endfunction

    // ALU operation for the I-type ALU group; addi falls through to add
    function automatic logic [2:0] alu_op_imm(input logic [5:0] op);
        return op == OP_SLTI ? ALU_SLT :
               op == OP_ORI  ? ALU_OR  :
               op == OP_LUI  ? ALU_LUI : ALU_ADD;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational decode of FSM state (+opcode) into the control word
//   i_state - current FSM state
//   i_op    - opcode from the instruction register
//   i_ready - effective memory-ready, masks PC/IR loads while FETCH waits
//   o_ctrl  - packed ctrl_t control word
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0]        i_state,
    input  logic [5:0]        i_op,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl
);

    ctrl_t w_c;

    always_comb begin
        w_c = '0;
        case (state_t'(i_state))
            S_FETCH: begin
                w_c.mem_read  = 1'b1;
                w_c.ir_write  = i_ready;
                w_c.pc_write  = i_ready;
                w_c.pc_src    = PCSRC_ALU;
                w_c.alu_src_b = SRCB_FOUR;
                w_c.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                w_c.alu_src_b = SRCB_BR;
                w_c.alu_op    = ALU_ADD;
                w_c.illegal   = !op_legal(i_op);
            end
            S_EXEC_R: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_REG;
                w_c.alu_op    = ALU_RTYPE;
            end
            S_WB_R: begin
                w_c.reg_dst   = 1'b1;
                w_c.reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_IMM;
                w_c.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                w_c.iord     = 1'b1;
                w_c.mem_read = 1'b1;
            end
            S_WB_MEM: begin
                w_c.mem_to_reg = 1'b1;
                w_c.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                w_c.iord      = 1'b1;
                w_c.mem_write = 1'b1;
            end
            S_BRANCH: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_REG;
                w_c.alu_op    = ALU_SUB;
                w_c.pc_src    = PCSRC_ALUOUT;
                w_c.branch    = i_op == OP_BEQ;
                w_c.branch_ne = i_op == OP_BNE;
            end
            S_EXEC_I: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_IMM;
                w_c.alu_op    = alu_op_imm(i_op);
                w_c.ext_zero  = i_op == OP_ORI;
            end
            S_WB_I: w_c.reg_write = 1'b1;
            S_JUMP: begin
                w_c.pc_write = 1'b1;
                w_c.pc_src   = PCSRC_JUMP;
            end
            default: w_c = '0;
        endcase
    end

    assign o_ctrl = w_c;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing fetch/decode/execute/memory/write-back for a multi-cycle MIPS
//   clk_i, rst_i (async, active-low)
//   instr_op_i   - opcode field, valid from DECODE onward
//   mem_ready_i  - memory done this cycle (ignored when MEM_HANDSHAKE=0)
//   *_o controls - datapath control signals, ALU_op_o, illegal_o pulse, state_o debug
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W       = 3,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         instr_op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               Branch_o,
    output logic               BranchNe_o,
    output logic [1:0]         PCSrc_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemtoReg_o,
    output logic               RegWrite_o,
    output logic               RegDst_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic               ExtZero_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic               illegal_o,
    output logic [3:0]         state_o
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_ready;

    assign w_ready = MEM_HANDSHAKE ? mem_ready_i : 1'b1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (instr_op_i)
                    OP_R:                               w_next = S_EXEC_R;
                    OP_LW, OP_SW:                       w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                     w_next = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ORI, OP_LUI:   w_next = S_EXEC_I;
                    OP_J:                               w_next = S_JUMP;
                    default:                            w_next = S_FETCH;
                endcase
            end
            S_EXEC_R:   w_next = S_WB_R;
            S_MEM_ADDR: w_next = instr_op_i == OP_LW ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = w_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   w_next = w_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_I:   w_next = S_WB_I;
            S_WB_R, S_WB_MEM, S_BRANCH, S_WB_I, S_JUMP: w_next = S_FETCH;
            default:    w_next = S_IDLE;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .i_state (r_state),
        .i_op    (instr_op_i),
        .i_ready (w_ready),
        .o_ctrl  (w_ctrl)
    );

    assign PCWrite_o  = w_ctrl.pc_write;
    assign Branch_o   = w_ctrl.branch;
    assign BranchNe_o = w_ctrl.branch_ne;
    assign PCSrc_o    = w_ctrl.pc_src;
    assign IorD_o     = w_ctrl.iord;
    assign MemRead_o  = w_ctrl.mem_read;
    assign MemWrite_o = w_ctrl.mem_write;
    assign IRWrite_o  = w_ctrl.ir_write;
    assign MemtoReg_o = w_ctrl.mem_to_reg;
    assign RegWrite_o = w_ctrl.reg_write;
    assign RegDst_o   = w_ctrl.reg_dst;
    assign ALUSrcA_o  = w_ctrl.alu_src_a;
    assign ALUSrcB_o  = w_ctrl.alu_src_b;
    assign ExtZero_o  = w_ctrl.ext_zero;
    assign ALU_op_o   = ALUOP_W'(w_ctrl.alu_op);
    assign illegal_o  = w_ctrl.illegal;
    assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] instr_op_i = 6'd0;
    logic       mem_ready_i = 1'b1;
    logic       PCWrite_o, Branch_o, BranchNe_o, IorD_o, MemRead_o, MemWrite_o;
    logic       IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, ExtZero_o, illegal_o;
    logic [1:0] PCSrc_o, ALUSrcB_o;
    logic [2:0] ALU_op_o;
    logic [3:0] state_o;
    logic [19:0] w_outs;
    int n_chk = 0;
    int n_pass = 0;
    int n_pcw = 0;

    multicycle_ctrl #(.ALUOP_W(3), .MEM_HANDSHAKE(1'b1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .instr_op_i  (instr_op_i),
        .mem_ready_i (mem_ready_i),
        .PCWrite_o   (PCWrite_o),
        .Branch_o    (Branch_o),
        .BranchNe_o  (BranchNe_o),
        .PCSrc_o     (PCSrc_o),
        .IorD_o      (IorD_o),
        .MemRead_o   (MemRead_o),
        .MemWrite_o  (MemWrite_o),
        .IRWrite_o   (IRWrite_o),
        .MemtoReg_o  (MemtoReg_o),
        .RegWrite_o  (RegWrite_o),
        .RegDst_o    (RegDst_o),
        .ALUSrcA_o   (ALUSrcA_o),
        .ALUSrcB_o   (ALUSrcB_o),
        .ExtZero_o   (ExtZero_o),
        .ALU_op_o    (ALU_op_o),
        .illegal_o   (illegal_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    assign w_outs = {PCWrite_o, Branch_o, BranchNe_o, PCSrc_o, IorD_o, MemRead_o, MemWrite_o,
                     IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, ALUSrcB_o,
                     ExtZero_o, ALU_op_o, illegal_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2 rst_i = 1'b0;
        #1;
        chk("rst_async_state", state_o, 4'd0);
        chk("rst_async_outs", w_outs, 20'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_state", state_o, 4'd0);
            chk("rst_outs", w_outs, 20'd0);
        end
        rst_i = 1'b1;
        #1;
        chk("idle_state", state_o, 4'd0);
        chk("idle_outs", w_outs, 20'd0);
        // R-type walk
        tick();
        chk("fetch_state", state_o, 4'd1);
        chk("fetch_ctl", {PCWrite_o, IRWrite_o, MemRead_o, IorD_o, ALUSrcA_o, ALUSrcB_o, PCSrc_o, ALU_op_o},
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010});
        tick();
        chk("decode_state", state_o, 4'd2);
        chk("decode_ctl", {ALUSrcA_o, ALUSrcB_o, ALU_op_o, illegal_o, PCWrite_o}, {1'b0, 2'b11, 3'b010, 1'b0, 1'b0});
        tick();
        chk("exec_r_state", state_o, 4'd3);
        chk("exec_r_ctl", {ALUSrcA_o, ALUSrcB_o, ALU_op_o, RegWrite_o}, {1'b1, 2'b00, 3'b000, 1'b0});
        tick();
        chk("wb_r_state", state_o, 4'd4);
        chk("wb_r_ctl", {RegWrite_o, RegDst_o, MemtoReg_o}, 3'b110);
        tick();
        chk("r_back_fetch", state_o, 4'd1);
        // lw with two wait cycles in MEM_RD
        instr_op_i = 6'd35;
        tick();
        chk("lw_decode", state_o, 4'd2);
        tick();
        chk("lw_mem_addr", state_o, 4'd5);
        chk("lw_addr_ctl", {ALUSrcA_o, ALUSrcB_o, ALU_op_o}, {1'b1, 2'b10, 3'b010});
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) mem_ready_i = 1'b1;
            #1;
            chk("lw_mem_rd_state", state_o, 4'd6);
            chk("lw_mem_rd_ctl", {MemRead_o, IorD_o, RegWrite_o}, 3'b110);
        end
        tick();
        chk("lw_wb_mem", state_o, 4'd7);
        chk("lw_wb_ctl", {MemtoReg_o, RegWrite_o, RegDst_o}, 3'b110);
        tick();
        chk("lw_back_fetch", state_o, 4'd1);
        // FETCH stall: PC must advance exactly once
        mem_ready_i = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_state", state_o, 4'd1);
            chk("stall_mask", {PCWrite_o, IRWrite_o, MemRead_o}, 3'b001);
            n_pcw += int'(PCWrite_o);
            tick();
        end
        mem_ready_i = 1'b1;
        instr_op_i = 6'd4;
        #1;
        chk("stall_ready_ctl", {PCWrite_o, IRWrite_o}, 2'b11);
        n_pcw += int'(PCWrite_o);
        chk("stall_pc_pulses", n_pcw, 1);
        // beq then bne
        tick();
        chk("beq_decode", state_o, 4'd2);
        tick();
        chk("beq_branch", state_o, 4'd9);
        chk("beq_ctl", {ALU_op_o, PCSrc_o, Branch_o, BranchNe_o, ALUSrcA_o, ALUSrcB_o},
            {3'b110, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00});
        tick();
        chk("beq_back_fetch", state_o, 4'd1);
        instr_op_i = 6'd5;
        tick();
        tick();
        chk("bne_branch", state_o, 4'd9);
        chk("bne_ctl", {ALU_op_o, PCSrc_o, Branch_o, BranchNe_o}, {3'b110, 2'b01, 1'b0, 1'b1});
        tick();
        chk("bne_back_fetch", state_o, 4'd1);
        // ori, lui, slti
        instr_op_i = 6'd13;
        tick();
        tick();
        chk("ori_exec_i", state_o, 4'd10);
        chk("ori_ctl", {ALU_op_o, ExtZero_o, ALUSrcA_o, ALUSrcB_o}, {3'b001, 1'b1, 1'b1, 2'b10});
        tick();
        chk("ori_wb_i", state_o, 4'd11);
        chk("ori_wb_ctl", {RegWrite_o, RegDst_o, MemtoReg_o}, 3'b100);
        tick();
        instr_op_i = 6'd15;
        tick();
        tick();
        chk("lui_exec_i", state_o, 4'd10);
        chk("lui_ctl", {ALU_op_o, ExtZero_o}, {3'b011, 1'b0});
        tick();
        tick();
        instr_op_i = 6'd10;
        tick();
        tick();
        chk("slti_ctl", {ALU_op_o, ExtZero_o}, {3'b111, 1'b0});
        tick();
        tick();
        // j
        instr_op_i = 6'd2;
        tick();
        tick();
        chk("j_state", state_o, 4'd12);
        chk("j_ctl", {PCWrite_o, PCSrc_o, RegWrite_o}, {1'b1, 2'b10, 1'b0});
        tick();
        chk("j_back_fetch", state_o, 4'd1);
        // illegal opcode
        instr_op_i = 6'd63;
        tick();
        chk("ill_decode", state_o, 4'd2);
        chk("ill_ctl", {illegal_o, RegWrite_o, MemWrite_o, PCWrite_o}, 4'b1000);
        tick();
        chk("ill_next_fetch", state_o, 4'd1);
        chk("ill_pulse_end", illegal_o, 1'b0);
        // sw, then reset while waiting in MEM_WR
        instr_op_i = 6'd43;
        tick();
        tick();
        chk("sw_mem_addr", state_o, 4'd5);
        mem_ready_i = 1'b0;
        tick();
        chk("sw_mem_wr", state_o, 4'd8);
        chk("sw_ctl", {MemWrite_o, IorD_o, MemRead_o}, 3'b110);
        #1 rst_i = 1'b0;
        #1;
        chk("sw_rst_memwrite", MemWrite_o, 1'b0);
        chk("sw_rst_state", state_o, 4'd0);
        chk("sw_rst_outs", w_outs, 20'd0);
        tick();
        chk("sw_rst_hold", state_o, 4'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
